fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  - Instruction fetch stage: owns the architectural PC and issues word fetches to instruction memory.
//  - Buffers returned {pc, inst} pairs for decode; accepts redirects (next address from branch resolution).
//  - Sits upstream of decode/branch resolution and consumes the resolved next address as redirect_addr.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset release
//  BUF_DEPTH  2              instruction buffer entries; power of 2, >=2
// PORTS
//  clk             in   1   clock; all state on posedge
//  rst_n           in   1   reset, asynchronous, active-low
//  imem_req        out  1   fetch request valid
//  imem_addr       out  32  fetch address, word aligned
//  imem_gnt        in   1   memory accepts request this cycle (imem_req && imem_gnt = issue)
//  imem_rvalid     in   1   read data valid; >=1 cycle after issue, in order
//  imem_rdata      in   32  instruction word
//  redirect_valid  in   1   one-cycle pulse: restart fetch at redirect_addr
//  redirect_addr   in   32  new fetch PC
//  inst_valid      out  1   buffer head valid to decode
//  inst_ready      in   1   decode accepts head (inst_valid && inst_ready = pop)
//  inst_pc         out  32  PC of head instruction
//  inst_data       out  32  head instruction word
//  misalign_err    out  1   sticky misaligned-redirect flag (FETCH_MISALIGN_CHECK_EN only)
// BEHAVIOUR
//  - Reset (async assert): imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_pc=0, inst_data=0,
//    buffer empty, fetch_pc=RESET_PC, state FETCH, misalign_err=0. First imem_req=1 on first posedge after release.
//  - Max one outstanding request. FSM states:
//    FETCH: imem_req=1 iff count+0 < BUF_DEPTH; on issue -> WAIT, fetch_pc+=4 (wraps 0xFFFF_FFFC -> 0).
//    WAIT : imem_req=0; on imem_rvalid push {issued pc, imem_rdata} -> FETCH.
//    DRAIN: imem_req=0; discard next imem_rvalid -> FETCH. Entered on redirect while a request is outstanding.
//    HALT : only with FETCH_MISALIGN_CHECK_EN; imem_req=0 until reset.
//  - Issue condition accounts for outstanding slot: no issue unless buffer has room for the response.
//  - Redirect (highest priority): flush buffer (inst_valid=0 next cycle), fetch_pc<=redirect_addr;
//    in FETCH (even if issuing same cycle) or WAIT -> DRAIN if a request is outstanding after this edge, else FETCH.
//    rvalid coincident with redirect is discarded. Redirect in DRAIN: update fetch_pc, stay DRAIN.
//    Pop coincident with redirect is ignored (flush wins).
//  - Buffer: simultaneous push and pop when full/non-empty allowed; head stable while inst_valid && !inst_ready.
//    inst_pc/inst_data hold last value when empty; decode qualifies with inst_valid.
//  - Latency: issue->push = memory latency; push->inst_valid = 1 cycle (registered buffer).
//  - Redirect->next imem_req: 1 cycle if nothing outstanding, else 1 cycle after the discarded rvalid.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: redirect_addr[1:0]!=0 sets misalign_err (sticky), flushes, enters HALT.
//  Undefined: redirect_addr[1:0] forced to 2'b00; misalign_err port absent; HALT state unreachable.
// STRUCTURE
//  - fetch_pkg: XLEN=32, ILEN=32, fetch_state_e {FETCH, WAIT, DRAIN, HALT}, fetch_entry_t {pc, inst}.
//  - Sub-module fetch_buffer: parameterised FIFO of fetch_entry_t with push/pop/flush/count.
//  - fetch_unit: FSM, PC register, outstanding-pc register, buffer instance.
// TESTING
//  1 Reset release, gnt=1, 1-cycle rvalid, ready=1 -> imem_addr 0x0,0x4,0x8; inst_pc 0x0,0x4 with matching rdata.
//  2 ready=0 with BUF_DEPTH=2 -> exactly 2 entries buffered, imem_req=0, head pc 0x0 held stable; ready=1 resumes.
//  3 Redirect 0x100 while in WAIT -> pending rvalid discarded, buffer flushed, next imem_addr=0x100, first inst_pc=0x100.
//  4 Redirect 0x200 same cycle as rvalid and pop -> no push, no pop effect, next imem_addr=0x200.
//  5 Redirect 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
//  6 With FETCH_MISALIGN_CHECK_EN, redirect 0x102 -> misalign_err=1 sticky, imem_req=0 until rst_n low; without, fetch at 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Used by fetch_buffer and fetch_unit.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, inst} pairs between fetch and decode.
// Head output holds its last value while the FIFO is empty.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         valid,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  hold_q;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign valid   = (cnt != '0);
    assign count   = cnt;
    assign do_pop  = pop && valid && !flush;
    assign do_push = push && !flush && ((cnt != CW'(DEPTH)) || do_pop);
    assign head    = valid ? mem[rd_ptr] : hold_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            hold_q <= '0;
        end else begin
            hold_q <= head;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                unique case ({do_push, do_pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem port, decode buffer.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects into HALT.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e  state_q;
    fetch_state_e  state_d;
    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [31:0]   opc_q;
    logic          started_q;
    logic          issue;
    logic          push;
    logic          pop;
    logic          redir_bad;
    logic [31:0]   redir_pc;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  din;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_pc  = redirect_addr;
    assign redir_bad = redirect_valid && (redirect_addr[1:0] != 2'b00);
`else
    assign redir_pc  = {redirect_addr[31:2], 2'b00};
    assign redir_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            opc_q     <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            started_q <= 1'b1;
            if (issue) begin
                opc_q <= pc_q;
            end
        end
    end

    // A redirect leaves DRAIN only if no response is still in flight.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redir_bad) begin
            state_d = HALT;
        end else if (redirect_valid && state_q != HALT) begin
            pc_d = redir_pc;
            if (issue) begin
                state_d = DRAIN;
            end else if (state_q != FETCH && !imem_rvalid) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end else begin
            unique case (1'b1)
                state_q == FETCH: begin
                    if (issue) begin
                        state_d = WAIT;
                        pc_d    = pc_q + 32'd4;
                    end
                end
                state_q == WAIT,
                state_q == DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        imem_req = 1'b0;
        if (state_q == FETCH && started_q) begin
            imem_req = (count < CW'(BUF_DEPTH));
        end
    end

    assign imem_addr = pc_q;
    assign issue     = imem_req && imem_gnt;
    assign push      = (state_q == WAIT) && imem_rvalid && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;
    assign din.pc    = opc_q;
    assign din.inst  = imem_rdata;
    assign inst_pc   = head.pc;
    assign inst_data = head.inst;

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redir_bad) begin
            misalign_err <= 1'b1;
        end
    end
`endif

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .head  (head),
        .valid (inst_valid),
        .count (count)
    );

endmodule
